// File: rtl/wide_add_seq_pkg.sv
// Shared types for the chunked wide-adder sequencer.
package wide_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage : wide_add_seq_pkg

// File: rtl/wide_add_slice.sv
// Registered SIZE-bit adder slice with carry in/out; one cycle of latency, no reset.
module wide_add_slice #(
    parameter int unsigned SIZE = 16
) (
    input  logic            clk,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            cout
);

    localparam int unsigned SW = SIZE + 1;

    always_ff @(posedge clk) begin
        {cout, s} <= SW'(a) + SW'(b) + SW'(cin);
    end

endmodule : wide_add_slice

// File: rtl/wide_add_seq.sv
// Sequences a WIDTH-bit add through one shared SIZE-bit slice, LS chunk first,
// chaining the slice's registered carry-out into the next chunk.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter  int unsigned SIZE   = 16,
    parameter  int unsigned CHUNKS = 4,
    localparam int unsigned WIDTH  = SIZE * CHUNKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int unsigned IDX_W = $clog2(CHUNKS);
    localparam int unsigned LAST  = CHUNKS - 1;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       accept, wr_chunk, finish;

    logic [CHUNKS-1:0][SIZE-1:0] a_q, b_q;
    logic                        cin_q;
    logic [SIZE-1:0]             result_q [CHUNKS-1];
    logic [CHUNKS-1:0][SIZE-1:0] s_asm;

    logic [SIZE-1:0] slice_a, slice_b, slice_s;
    logic            slice_cin, slice_cout;

    // State and chunk index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        accept   = 1'b0;
        wr_chunk = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                wr_chunk = (idx_q != '0);
                if (idx_q == IDX_W'(LAST)) begin
                    state_d = FLUSH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FLUSH: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slice feed: first chunk takes the latched carry-in, later ones the slice's own carry
    assign slice_a   = a_q[idx_q];
    assign slice_b   = b_q[idx_q];
    assign slice_cin = (idx_q == '0) ? cin_q : slice_cout;

    wide_add_slice #(
        .SIZE (SIZE)
    ) u_slice (
        .clk  (clk),
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Operand capture and lower result chunks; contents are don't-care outside an operation
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
        end
        if (wr_chunk) begin
            result_q[idx_q - IDX_W'(1)] <= slice_s;
        end
    end

    // Top chunk comes straight from the slice in the FLUSH cycle
    always_comb begin
        s_asm = '0;
        for (int k = 0; k < int'(LAST); k++) begin
            s_asm[k] = result_q[k];
        end
        s_asm[LAST] = slice_s;
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            s    <= '0;
            cout <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= finish;
            if (finish) begin
                s    <= s_asm;
                cout <= slice_cout;
            end
        end
    end

endmodule : wide_add_seq

// File: tb/tb_wide_add_seq.sv
// Directed and randomized checks of wide_add_seq against a plain (WIDTH+1)-bit add.
module tb_wide_add_seq;

    localparam int unsigned SIZE   = 16;
    localparam int unsigned CHUNKS = 4;
    localparam int unsigned WIDTH  = SIZE * CHUNKS;
    localparam int          LAT    = CHUNKS + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    int n_cmp = 0;
    int n_err = 0;

    wide_add_seq #(
        .SIZE   (SIZE),
        .CHUNKS (CHUNKS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; operands are scrambled afterwards and must not matter
    task automatic launch(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = {$urandom(), $urandom()};
        b     = {$urandom(), $urandom()};
        cin   = 1'($urandom());
    endtask

    // Wait (bounded) for done; pre = edges already elapsed since the accepting edge
    task automatic wait_done(input string tag, input logic [WIDTH:0] expv, input int pre);
        int cyc  = pre;
        bit seen = 1'b0;
        while (!seen && cyc < 4 * LAT) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
            else      chk({tag, "/busy"}, (WIDTH+1)'(busy), (WIDTH+1)'(1));
        end
        chk({tag, "/latency"}, (WIDTH+1)'(cyc), (WIDTH+1)'(LAT));
        chk({tag, "/busy_at_done"}, (WIDTH+1)'(busy), (WIDTH+1)'(0));
        chk({tag, "/sum"}, {cout, s}, expv);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic);
        logic [WIDTH:0] expv;
        expv = model(ia, ib, ic);
        launch(ia, ib, ic);
        wait_done(tag, expv, 0);
    endtask

    initial begin
        int             n_done;
        logic [WIDTH-1:0] ra, rb;
        logic           rc;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) tick();
        chk("reset/busy", (WIDTH+1)'(busy), (WIDTH+1)'(0));
        chk("reset/done", (WIDTH+1)'(done), (WIDTH+1)'(0));
        chk("reset/sum",  {cout, s}, '0);
        rst = 1'b0;
        tick();

        run_op("1+2", 64'd1, 64'd2, 1'b0);
        tick();
        chk("1+2/done_pulse", (WIDTH+1)'(done), (WIDTH+1)'(0));
        chk("1+2/hold", {cout, s}, (WIDTH+1)'(3));

        run_op("ones+cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        run_op("ffff+1", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);

        // Start pulsed while busy is ignored
        launch(64'd10, 64'd20, 1'b0);
        tick();
        a     = 64'd5;
        b     = 64'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", model(64'd10, 64'd20, 1'b0), 2);
        n_done = 0;
        repeat (2 * LAT) begin
            tick();
            if (done) n_done++;
        end
        chk("busy_start/extra_done", (WIDTH+1)'(n_done), (WIDTH+1)'(0));

        // Reset in RUN at idx=2
        launch(64'd123, 64'd456, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/busy", (WIDTH+1)'(busy), (WIDTH+1)'(0));
        chk("midrst/done", (WIDTH+1)'(done), (WIDTH+1)'(0));
        chk("midrst/sum",  {cout, s}, '0);
        run_op("7+8", 64'd7, 64'd8, 1'b0);

        // Launched in the done cycle of 7+8
        run_op("100+200", 64'd100, 64'd200, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom());
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = ~ra;
                2: begin ra = '1; rb = '1; end
                default: ;
            endcase
            run_op("random", ra, rb, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wide_add_seq
